// File: rtl/gtx_reset_sequencer.sv
// gtx_reset_sequencer: PMA/PCS reset sequencing with lock/done timeouts and retry count; optional RX elecidle recovery under GTX_RESET_SEQ_ELECIDLE_RECOVER_EN
module gtx_reset_sequencer #(
  parameter int          LANES            = 4,
  parameter int          PMA_RESET_CYCLES = 16,
  parameter int          PCS_RESET_CYCLES = 8,
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd1000000,
  parameter int          ELECIDLE_CYCLES  = 256
) (
  input  logic             gtx_refclk_bufr,
  input  logic             mgt_reset,
  input  logic [LANES-1:0] pll_lock,
  input  logic [LANES-1:0] tx_resetdone,
  input  logic [LANES-1:0] rx_resetdone,
  input  logic [LANES-1:0] rx_elecidle,
  output logic             pma_reset,
  output logic             tx_pcs_reset,
  output logic             rx_pcs_reset,
  output logic             tx_ready,
  output logic             rx_ready,
  output logic [7:0]       retry_count,
  output logic [2:0]       seq_state
);
  typedef enum logic [2:0] {
    PMA_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    PCS_RST   = 3'd2,
    WAIT_DONE = 3'd3,
    READY     = 3'd4,
    RX_RST    = 3'd5
  } state_t;
  localparam logic [23:0] PMA_END = 24'(PMA_RESET_CYCLES - 1);
  localparam logic [23:0] PCS_LEN = 24'(PCS_RESET_CYCLES);
  localparam logic [23:0] PCS_END = 24'(PCS_RESET_CYCLES - 1);
  localparam logic [23:0] TO_END  = TIMEOUT_CYCLES - 24'd1;
  localparam logic [23:0] RX_END  = 24'(PCS_RESET_CYCLES) + TIMEOUT_CYCLES - 24'd1;
`ifdef GTX_RESET_SEQ_ELECIDLE_RECOVER_EN
  localparam state_t LAST = RX_RST;
`else
  localparam state_t LAST = READY;
`endif
  state_t           r_state, w_next;
  logic [23:0]      r_cnt, w_cnt_nxt;
  logic [7:0]       r_retry;
  logic             r_pma, r_txpcs, r_rxpcs, r_txrdy, r_rxrdy;
  logic [LANES-1:0] r_lock_s1, r_lock_s2, r_txd_s1, r_txd_s2, r_rxd_s1, r_rxd_s2;
  logic             w_all_lock, w_all_txdone, w_all_rxdone, w_retry;
  assign w_all_lock   = &r_lock_s2;
  assign w_all_txdone = &r_txd_s2;
  assign w_all_rxdone = &r_rxd_s2;
  // two-flop synchronizers for the asynchronous lane status buses
  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset)
    if (mgt_reset) begin
      {r_lock_s1, r_lock_s2, r_txd_s1, r_txd_s2, r_rxd_s1, r_rxd_s2} <= '0;
    end else begin
      {r_lock_s1, r_lock_s2} <= {pll_lock, r_lock_s1};
      {r_txd_s1, r_txd_s2}   <= {tx_resetdone, r_txd_s1};
      {r_rxd_s1, r_rxd_s2}   <= {rx_resetdone, r_rxd_s1};
    end
`ifdef GTX_RESET_SEQ_ELECIDLE_RECOVER_EN
  localparam int IW = $clog2(ELECIDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_END = IW'(ELECIDLE_CYCLES - 1);
  logic [LANES-1:0] r_idle_s1, r_idle_s2;
  logic [IW-1:0]    r_idle_cnt;
  logic             w_idle, w_idle_hit;
  assign w_idle     = r_state == READY && |r_idle_s2;
  assign w_idle_hit = w_idle && r_idle_cnt == IDLE_END;
  // consecutive-elecidle run length while READY; any clean cycle restarts it
  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset)
    if (mgt_reset) begin
      {r_idle_s1, r_idle_s2} <= '0;
      r_idle_cnt <= '0;
    end else begin
      {r_idle_s1, r_idle_s2} <= {rx_elecidle, r_idle_s1};
      r_idle_cnt <= (w_idle && !w_idle_hit) ? r_idle_cnt + 1'b1 : '0;
    end
`endif
  // next-state logic; lock loss is checked first so it beats every other event
  always_comb begin
    w_next = r_state;
    case (r_state)
      PMA_RST:   w_next = r_cnt == PMA_END ? WAIT_LOCK : PMA_RST;
      WAIT_LOCK: w_next = w_all_lock ? PCS_RST : r_cnt == TO_END ? PMA_RST : WAIT_LOCK;
      PCS_RST:   w_next = !w_all_lock ? PMA_RST : r_cnt == PCS_END ? WAIT_DONE : PCS_RST;
      WAIT_DONE: w_next = !w_all_lock ? PMA_RST : (w_all_txdone && w_all_rxdone) ? READY :
                          r_cnt == TO_END ? PMA_RST : WAIT_DONE;
`ifdef GTX_RESET_SEQ_ELECIDLE_RECOVER_EN
      READY:     w_next = !w_all_lock ? PMA_RST : w_idle_hit ? RX_RST : READY;
      RX_RST:    w_next = !w_all_lock ? PMA_RST : (r_cnt >= PCS_LEN && w_all_rxdone) ? READY :
                          r_cnt == RX_END ? PMA_RST : RX_RST;
`else
      READY:     w_next = !w_all_lock ? PMA_RST : READY;
`endif
      default:   w_next = PMA_RST;
    endcase
    w_retry   = w_next == PMA_RST && r_state != PMA_RST && r_state <= LAST;
    w_cnt_nxt = w_next != r_state ? '0 : &r_cnt ? r_cnt : r_cnt + 24'd1;
  end
  // state, cycle counter, retry counter and outputs decoded from the next state
  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset)
    if (mgt_reset) begin
      r_state <= PMA_RST;
      r_cnt   <= '0;
      r_retry <= '0;
      {r_pma, r_txpcs, r_rxpcs, r_txrdy, r_rxrdy} <= 5'b11100;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_retry <= r_retry + 8'(w_retry && r_retry != 8'hFF);
      r_pma   <= w_next == PMA_RST;
      r_txpcs <= w_next inside {PMA_RST, WAIT_LOCK, PCS_RST};
      r_rxpcs <= w_next inside {PMA_RST, WAIT_LOCK, PCS_RST} || (w_next == RX_RST && w_cnt_nxt < PCS_LEN);
      r_txrdy <= w_next inside {READY, RX_RST};
      r_rxrdy <= w_next == READY;
    end
  assign pma_reset    = r_pma;
  assign tx_pcs_reset = r_txpcs;
  assign rx_pcs_reset = r_rxpcs;
  assign tx_ready     = r_txrdy;
  assign rx_ready     = r_rxrdy;
  assign retry_count  = r_retry;
  assign seq_state    = r_state;
endmodule

// File: tb/tb_gtx_reset_sequencer.sv
// tb_gtx_reset_sequencer: directed bench for the GTX reset sequencer
module tb_gtx_reset_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] lock = '0, txd = '0, rxd = '0, idle = '0;
  logic       pma, txpcs, rxpcs, txrdy, rxrdy;
  logic [7:0] retry;
  logic [2:0] st;
  int         n_chk = 0, n_bad = 0;
  gtx_reset_sequencer #(
    .LANES(4), .PMA_RESET_CYCLES(16), .PCS_RESET_CYCLES(8),
    .TIMEOUT_CYCLES(24'd100), .ELECIDLE_CYCLES(32)
  ) dut (
    .gtx_refclk_bufr(clk), .mgt_reset(rst), .pll_lock(lock),
    .tx_resetdone(txd), .rx_resetdone(rxd), .rx_elecidle(idle),
    .pma_reset(pma), .tx_pcs_reset(txpcs), .rx_pcs_reset(rxpcs),
    .tx_ready(txrdy), .rx_ready(rxrdy), .retry_count(retry), .seq_state(st)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rst_vals(input string tag);
    chk({tag, "_pma"}, pma, 1);
    chk({tag, "_txpcs"}, txpcs, 1);
    chk({tag, "_rxpcs"}, rxpcs, 1);
    chk({tag, "_txrdy"}, txrdy, 0);
    chk({tag, "_rxrdy"}, rxrdy, 0);
    chk({tag, "_retry"}, retry, 0);
    chk({tag, "_state"}, st, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst_vals("rst");
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    tick(15);
    chk("nom_pma_hold", pma, 1);
    tick(1);
    chk("nom_pma_fall", pma, 0);
    chk("nom_wait_lock", st, 1);
    tick(13);
    lock = 4'hF;
    tick(2);
    chk("nom_lock_sync", st, 1);
    tick(1);
    chk("nom_pcs_rst", st, 2);
    tick(7);
    chk("nom_pcs_hold", txpcs, 1);
    tick(1);
    chk("nom_wait_done", st, 3);
    chk("nom_txpcs_fall", txpcs, 0);
    chk("nom_rxpcs_fall", rxpcs, 0);
    tick(19);
    txd = 4'hF;
    rxd = 4'hF;
    tick(2);
    chk("nom_done_sync", st, 3);
    tick(1);
    chk("nom_ready", st, 4);
    chk("nom_txrdy", txrdy, 1);
    chk("nom_rxrdy", rxrdy, 1);
    chk("nom_retry", retry, 0);
    txd = 4'h0;
    tick(6);
    chk("txdone_drop_state", st, 4);
    chk("txdone_drop_txrdy", txrdy, 1);
    txd = 4'hF;
    tick(3);
    lock = 4'hB;
    tick(1);
    lock = 4'hF;
    tick(2);
    chk("loss_state", st, 0);
    chk("loss_txrdy", txrdy, 0);
    chk("loss_rxrdy", rxrdy, 0);
    chk("loss_pma", pma, 1);
    chk("loss_retry", retry, 1);
    tick(25);
    chk("loss_rerun_wd", st, 3);
    tick(1);
    chk("loss_rerun_ready", st, 4);
    chk("loss_rerun_retry", retry, 1);
    rxd = 4'hE;
    do_reset();
    tick(25);
    chk("rd_wait_done", st, 3);
    tick(99);
    chk("rd_before_to", st, 3);
    tick(1);
    chk("rd_to_state", st, 0);
    chk("rd_to_retry", retry, 1);
    chk("rd_to_pma", pma, 1);
    tick(25);
    chk("ar_wait_done", st, 3);
    tick(10);
    #1 rst = 1'b1;
    #1 rst_vals("async");
    #1 rst = 1'b0;
    lock = 4'h7;
    rxd = 4'hF;
    @(negedge clk);
    tick(15);
    chk("lto_wait_lock", st, 1);
    tick(99);
    chk("lto_before", st, 1);
    tick(1);
    chk("lto_state", st, 0);
    chk("lto_retry1", retry, 1);
    tick(116);
    chk("lto_retry2", retry, 2);
    tick(116 * 252);
    chk("lto_retry_fe", retry, 8'hFE);
    tick(116);
    chk("lto_retry_ff", retry, 8'hFF);
    tick(116 * 50);
    chk("lto_retry_sat", retry, 8'hFF);
    chk("lto_sat_state", st, 0);
    lock = 4'hF;
    do_reset();
    tick(26);
    chk("ei_ready", st, 4);
`ifdef GTX_RESET_SEQ_ELECIDLE_RECOVER_EN
    idle = 4'h1;
    tick(31);
    idle = 4'h0;
    tick(5);
    chk("ei_short_state", st, 4);
    chk("ei_short_rxrdy", rxrdy, 1);
    idle = 4'h1;
    tick(33);
    chk("ei_pre_state", st, 4);
    tick(1);
    chk("ei_rxrst_state", st, 5);
    chk("ei_rxrst_rxrdy", rxrdy, 0);
    chk("ei_rxrst_txrdy", txrdy, 1);
    chk("ei_rxrst_rxpcs", rxpcs, 1);
    chk("ei_rxrst_txpcs", txpcs, 0);
    chk("ei_rxrst_pma", pma, 0);
    tick(6);
    idle = 4'h0;
    tick(1);
    chk("ei_rxpcs_hold", rxpcs, 1);
    tick(1);
    chk("ei_rxpcs_fall", rxpcs, 0);
    tick(1);
    chk("ei_back_ready", st, 4);
    chk("ei_back_rxrdy", rxrdy, 1);
    chk("ei_back_retry", retry, 0);
`else
    idle = 4'h1;
    tick(40);
    idle = 4'h0;
    chk("ei_ignored_state", st, 4);
    chk("ei_ignored_rxrdy", rxrdy, 1);
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/gtx_reset_sequencer.md
Name: gtx_reset_sequencer

Overview:
- Per-refclk-group reset controller for one GTX quad group. It sits on the opposite side of the GTX reset interface from the quad wrappers.
- Drives the PMA/PLL reset and the TX/RX PCS resets. Consumes each lane's PLL-lock and reset-done status, and declares the link TX/RX ready.
- On lock timeout, reset-done timeout, or loss of lock, it restarts the whole sequence and counts the retry.
- One instance per refclk group (groups of 2 or 3 quads), clocked by that group's gtx_refclk_bufr.

Parameters:
- LANES, 4, number of status lanes monitored (1..12).
- PMA_RESET_CYCLES, 16, cycles pma_reset is held high per attempt (>=2).
- PCS_RESET_CYCLES, 8, cycles tx/rx PCS resets are held high (>=2).
- TIMEOUT_CYCLES, 24'd1000000, max cycles to wait for lock or reset-done (>=2, <2^24).
- ELECIDLE_CYCLES, 256, consecutive elecidle cycles before RX recovery (optional feature only).

Ports:
- gtx_refclk_bufr  in  1  sequencer clock.
- mgt_reset  in  1  asynchronous, active-high reset.
- pll_lock  in  LANES  per-lane RXPLLLKDET; asynchronous.
- tx_resetdone  in  LANES  per-lane TXRESETDONE; asynchronous.
- rx_resetdone  in  LANES  per-lane RXRESETDONE; asynchronous.
- rx_elecidle  in  LANES  per-lane RXELECIDLE; asynchronous.
- pma_reset  out  1  to GTXRXRESET/GTXTXRESET/PLLRXRESET/RXCDRRESET.
- tx_pcs_reset  out  1  to TXRESET.
- rx_pcs_reset  out  1  to RXRESET/RXBUFRESET.
- tx_ready  out  1  TX path usable.
- rx_ready  out  1  RX path usable.
- retry_count  out  8  failed-attempt counter, saturating.
- seq_state  out  3  current state encoding.

Behaviour:
- Reset is decided: mgt_reset, asynchronous, active-high; clock gtx_refclk_bufr.
- During and after reset, all outputs take these values:
  - pma_reset=1, tx_pcs_reset=1, rx_pcs_reset=1;
  - tx_ready=0, rx_ready=0;
  - retry_count=0, seq_state=PMA_RST;
  - cycle counter=0, synchronizers=0.
- All four status buses pass through 2-flop synchronizers; status latency is 2 cycles. FSM decisions use the synchronized values only: all_lock, all_txdone, all_rxdone (AND-reduce).
- All outputs are registered, decoded from the next state, so they change on the same edge as the state transition.
- A single 24-bit counter clears on every state entry.
- States and encodings:
  - PMA_RST=0: pma_reset=1, both PCS resets=1. After PMA_RESET_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK=1: pma_reset=0, PCS resets=1.
    - all_lock -> PCS_RST.
    - Else, counter reaches TIMEOUT_CYCLES-1 -> PMA_RST, retry_count+1.
  - PCS_RST=2: PCS resets=1. After PCS_RESET_CYCLES cycles -> WAIT_DONE.
    - all_lock dropping -> PMA_RST, retry_count+1.
  - WAIT_DONE=3: PCS resets=0.
    - all_txdone & all_rxdone & all_lock -> READY.
    - Timeout or lock loss -> PMA_RST, retry_count+1.
  - READY=4: tx_ready=1, rx_ready=1.
    - Any synchronized lock bit low -> PMA_RST, retry_count+1. tx_ready/rx_ready drop on that same edge.
  - RX_RST=5: optional feature only; see below.
  - Codes 6 and 7 are illegal and go to PMA_RST with no retry increment.
- retry_count saturates at 8'hFF and clears only on mgt_reset.
- If a timeout and the success condition occur in the same cycle, success wins.
- Lock loss has priority over every other event in every state.
- tx_resetdone dropping in READY is ignored; only lock loss forces a restart.
- mgt_reset asserted mid-sequence returns to the reset values immediately (asynchronously), regardless of state.
- Counters never wrap: every terminal count forces a transition.

Optional Feature:
- Macro: GTX_RESET_SEQ_ELECIDLE_RECOVER_EN.
- When defined:
  - In READY, a counter tracks consecutive cycles with any rx_elecidle bit set (synchronized); it clears on any idle-free cycle.
  - On reaching ELECIDLE_CYCLES -> RX_RST.
  - RX_RST: rx_pcs_reset=1 for PCS_RESET_CYCLES, rx_ready=0, tx_ready stays 1, pma_reset=0, tx_pcs_reset=0.
  - Then it waits up to TIMEOUT_CYCLES for all_rxdone -> READY. No retry increment on this path.
  - Timeout or lock loss in RX_RST -> PMA_RST, retry_count+1.
- When undefined: rx_elecidle is unused, RX_RST is unreachable (treated as illegal), and the elecidle counter is absent.

Test Plan (PMA_RESET_CYCLES=16, PCS_RESET_CYCLES=8, TIMEOUT_CYCLES=100, LANES=4, ELECIDLE_CYCLES=32):
- Nominal bring-up: release reset; drive pll_lock=4'hF at cycle 30 and resetdone=4'hF at cycle 60 -> pma_reset falls at cycle 16; PCS resets fall 8 cycles after lock is seen (+2 sync); tx_ready=rx_ready=1; retry_count=0; seq_state=4.
- Lock timeout: hold pll_lock=4'h7 -> after 100 cycles in WAIT_LOCK, seq_state=0 and retry_count=1; the attempt repeats; after 300 attempts retry_count stays 8'hFF.
- Lock loss in READY: from READY, drop pll_lock[2] for 1 cycle -> 2 cycles later both ready outputs=0, pma_reset=1, retry_count+1, full sequence reruns.
- Resetdone timeout: lock OK, rx_resetdone=4'hE -> WAIT_DONE times out at 100 cycles, seq_state=0, retry_count=1.
- Async reset mid-WAIT_DONE: pulse mgt_reset for 1 ns between edges -> all outputs return to reset values without waiting for a clock edge.
- With GTX_RESET_SEQ_ELECIDLE_RECOVER_EN: in READY, rx_elecidle[0]=1 for 40 cycles:
  - rx_ready=0, rx_pcs_reset=1 for 8 cycles, tx_ready stays 1;
  - rx_resetdone=4'hF -> READY, retry_count unchanged;
  - a 31-cycle idle burst causes no action.
